// File: rtl/audio_pkg.sv
// Shared select codes, clip lengths and FSM encoding for the audio event scheduler.
package audio_pkg;
  localparam logic [1:0] SEL_HIT   = 2'b00;
  localparam logic [1:0] SEL_SCORE = 2'b01;
  localparam logic [1:0] SEL_WIN   = 2'b10;
  localparam logic [1:0] SEL_OFF   = 2'b11;

  localparam logic [3:0] LEN_HIT   = 4'd1;
  localparam logic [3:0] LEN_SCORE = 4'd3;
  localparam logic [3:0] LEN_WIN   = 4'd11;

  typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_t;

  function automatic logic [3:0] clip_len(input logic [1:0] sel);
    case (sel)
      SEL_WIN:   return LEN_WIN;
      SEL_SCORE: return LEN_SCORE;
      default:   return LEN_HIT;
    endcase
  endfunction
endpackage

// File: rtl/audio_prio_pick.sv
// Combinational fixed-priority pick (win > score > hit) over a request vector {win, score, hit}.
module audio_prio_pick
  import audio_pkg::*;
(
  input  logic [2:0] req,
  output logic       vld,
  output logic [1:0] sel
);
  always_comb begin
    vld = |req;
    sel = SEL_OFF;
    if (req[2])      sel = SEL_WIN;
    else if (req[1]) sel = SEL_SCORE;
    else if (req[0]) sel = SEL_HIT;
  end
endmodule

// File: rtl/audio_event_scheduler.sv
// Arbitrates game sound events onto the game_audio synth and times each clip.
// Optional AUDIO_SCHED_STATS_EN adds a saturating dropped-event counter (drop_cnt).
module audio_event_scheduler
  import audio_pkg::*;
#(
  parameter int NOTE_CYC = 4194304,
  parameter int GAP_CYC  = 1048576
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit_evt,
  input  logic       score_evt,
  input  logic       win_evt,
  input  logic       mute,
  output logic [1:0] music_sel,
  output logic       play_rst,
`ifdef AUDIO_SCHED_STATS_EN
  output logic [7:0] drop_cnt,
`endif
  output logic       busy
);
  localparam int NW = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  state_t        state, state_n;
  logic [1:0]    cls, cls_n;
  logic [2:0]    pend, pend_n;
  logic [3:0]    notes_left, notes_left_n;
  logic [NW-1:0] note_cnt, note_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic [1:0]    sel_n;
  logic          play_rst_n, busy_n, go;

  logic       active, pick_vld;
  logic [1:0] pick_sel;
  logic [2:0] evt, act_mask, drop, acc, req, clr_mask;

  // Events of a class already pending or currently sounding are dropped.
  assign active   = (state == START) || (state == PLAY);
  assign evt      = {win_evt, score_evt, hit_evt} & {3{~mute}};
  assign act_mask = active ? (3'b001 << cls) : 3'b000;
  assign drop     = evt & (pend | act_mask);
  assign acc      = evt & ~drop;
  assign req      = pend | acc;
  assign clr_mask = (pick_sel == SEL_WIN) ? 3'b111 : (3'b001 << pick_sel);

  audio_prio_pick u_pick (
    .req (req),
    .vld (pick_vld),
    .sel (pick_sel)
  );

  always_comb begin
    state_n      = state;
    cls_n        = cls;
    pend_n       = req;
    notes_left_n = notes_left;
    note_cnt_n   = note_cnt;
    gap_cnt_n    = gap_cnt;
    go           = 1'b0;
    unique case (state)
      IDLE: go = pick_vld;
      START, PLAY: begin
        if (pick_vld && (pick_sel > cls)) begin
          go = 1'b1;
        end else if (state == START) begin
          state_n = PLAY;
        end else if (note_cnt != '0) begin
          note_cnt_n = note_cnt - 1'b1;
        end else if (notes_left != 4'd0) begin
          note_cnt_n   = NW'(NOTE_CYC - 1);
          notes_left_n = notes_left - 4'd1;
        end else if (GAP_CYC == 0) begin
          state_n = IDLE;
          go      = pick_vld;
        end else begin
          state_n   = GAP;
          gap_cnt_n = GW'(GAP_CYC - 1);
        end
      end
      GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_n = gap_cnt - 1'b1;
        end else begin
          state_n = IDLE;
          go      = pick_vld;
        end
      end
      default: state_n = IDLE;
    endcase
    if (go) begin
      state_n      = START;
      cls_n        = pick_sel;
      notes_left_n = clip_len(pick_sel) - 4'd1;
      note_cnt_n   = NW'(NOTE_CYC - 1);
      pend_n       = req & ~clr_mask;
    end
    if (mute) begin
      state_n = IDLE;
      cls_n   = SEL_OFF;
      pend_n  = 3'b000;
    end
    sel_n      = ((state_n == START) || (state_n == PLAY)) ? cls_n : SEL_OFF;
    play_rst_n = (state_n == START);
    busy_n     = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cls        <= SEL_OFF;
      pend       <= 3'b000;
      notes_left <= 4'd0;
      note_cnt   <= '0;
      gap_cnt    <= '0;
      music_sel  <= SEL_OFF;
      play_rst   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cls        <= cls_n;
      pend       <= pend_n;
      notes_left <= notes_left_n;
      note_cnt   <= note_cnt_n;
      gap_cnt    <= gap_cnt_n;
      music_sel  <= sel_n;
      play_rst   <= play_rst_n;
      busy       <= busy_n;
    end
  end

`ifdef AUDIO_SCHED_STATS_EN
  logic [1:0] ndrop;
  logic [8:0] drop_sum;
  assign ndrop    = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
  assign drop_sum = {1'b0, drop_cnt} + 9'(ndrop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= 8'd0;
    else     drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`endif
endmodule
